// File: rtl/register_file_if.sv
// Issue, commit and read-port bundle shared between the issue/ROB logic (master)
// and the architectural register file (slave).
interface register_file_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 clear_signal;
  logic                 issue_signal;
  logic [4:0]           issue_rd;
  logic [ROB_WIDTH-1:0] issue_tag;
  logic                 reg_done;
  logic [31:0]          reg_value;
  logic [ROB_WIDTH-1:0] reg_tag;
  logic [4:0]           rs1_addr;
  logic [4:0]           rs2_addr;
  logic [31:0]          rs1_value;
  logic [31:0]          rs2_value;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [ROB_WIDTH-1:0] rs1_tag;
  logic [ROB_WIDTH-1:0] rs2_tag;

  modport master (
    output clear_signal, issue_signal, issue_rd, issue_tag,
    output reg_done, reg_value, reg_tag, rs1_addr, rs2_addr,
    input  rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );

  modport slave (
    input  clear_signal, issue_signal, issue_rd, issue_tag,
    input  reg_done, reg_value, reg_tag, rs1_addr, rs2_addr,
    output rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );
endinterface

// File: rtl/register_file.sv
// Architectural register file with ROB rename tags: issue marks rd busy under a tag,
// commit writes the value back and frees the rename only if the tag is still current.
module register_file #(
  parameter int ROB_WIDTH = 4,
  parameter int ROB_SIZE  = 2**ROB_WIDTH
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  register_file_if.slave bus
);

  logic [31:0]          value_q [32];
  logic [31:0]          busy_q;
  logic [ROB_WIDTH-1:0] tag_q [32];
  logic [4:0]           rd_of_tag_q [ROB_SIZE];

  logic       issue_en;
  logic [4:0] commit_rd;
  logic       commit_frees;
  logic       bypass_en;

  assign issue_en  = bus.issue_signal & ~bus.clear_signal;
  assign commit_rd = rd_of_tag_q[bus.reg_tag];
  // A rename to the same rd in the committing cycle keeps it busy under the new tag.
  assign commit_frees = busy_q[commit_rd] && (tag_q[commit_rd] == bus.reg_tag) &&
                        !(issue_en && (bus.issue_rd == commit_rd));
  assign bypass_en = bus.reg_done & rdy_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd_of_tag_q[i] <= '0;
      end
    end else if (rdy_in) begin
      if (issue_en) begin
        rd_of_tag_q[bus.issue_tag] <= bus.issue_rd;
        if (bus.issue_rd != 5'd0) begin
          busy_q[bus.issue_rd] <= 1'b1;
          tag_q[bus.issue_rd]  <= bus.issue_tag;
        end
      end
      if (bus.reg_done && (commit_rd != 5'd0)) begin
        value_q[commit_rd] <= bus.reg_value;
        if (commit_frees) begin
          busy_q[commit_rd] <= 1'b0;
        end
      end
      // Flush wins over any rename issued or freed this cycle.
      if (bus.clear_signal) begin
        busy_q <= '0;
      end
    end
  end

  always_comb begin
    bus.rs1_value = value_q[bus.rs1_addr];
    bus.rs1_busy  = busy_q[bus.rs1_addr];
    bus.rs1_tag   = tag_q[bus.rs1_addr];
    bus.rs2_value = value_q[bus.rs2_addr];
    bus.rs2_busy  = busy_q[bus.rs2_addr];
    bus.rs2_tag   = tag_q[bus.rs2_addr];
    if (bypass_en && (bus.rs1_addr != 5'd0) && (bus.rs1_addr == commit_rd) &&
        busy_q[bus.rs1_addr] && (tag_q[bus.rs1_addr] == bus.reg_tag)) begin
      bus.rs1_value = bus.reg_value;
      bus.rs1_busy  = 1'b0;
    end
    if (bypass_en && (bus.rs2_addr != 5'd0) && (bus.rs2_addr == commit_rd) &&
        busy_q[bus.rs2_addr] && (tag_q[bus.rs2_addr] == bus.reg_tag)) begin
      bus.rs2_value = bus.reg_value;
      bus.rs2_busy  = 1'b0;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: rename, commit, stale tags, bypass, flush, x0 and stall.
module tb_register_file;

  localparam int ROB_WIDTH = 4;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  int   compared = 0;
  int   mismatched = 0;

  register_file_if #(.ROB_WIDTH(ROB_WIDTH)) bus ();

  register_file #(.ROB_WIDTH(ROB_WIDTH)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.clear_signal = 1'b0;
    bus.issue_signal = 1'b0;
    bus.issue_rd     = 5'd0;
    bus.issue_tag    = '0;
    bus.reg_done     = 1'b0;
    bus.reg_value    = 32'd0;
    bus.reg_tag      = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [ROB_WIDTH-1:0] tg);
    bus.issue_signal = 1'b1;
    bus.issue_rd     = rd;
    bus.issue_tag    = tg;
    tick();
    idle();
    #1;
  endtask

  task automatic test_reset();
    idle();
    rdy_in = 1'b1;
    rst_in = 1'b1;
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd0;
    tick();
    tick();
    rst_in = 1'b0;
    #1;
    compared++; if (bus.rs1_value !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_rs1_value got %h want %h", bus.rs1_value, 32'd0); end
    compared++; if (bus.rs1_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rs1_busy got %b want 0", bus.rs1_busy); end
    compared++; if (bus.rs1_tag !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_rs1_tag got %0d want 0", bus.rs1_tag); end
    compared++; if (bus.rs2_value !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_rs2_value got %h want %h", bus.rs2_value, 32'd0); end
    compared++; if (bus.rs2_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rs2_busy got %b want 0", bus.rs2_busy); end
    compared++; if (bus.rs2_tag !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_rs2_tag got %0d want 0", bus.rs2_tag); end
  endtask

  task automatic test_issue_commit();
    issue(5'd3, 4'd2);
    bus.rs1_addr = 5'd3;
    #1;
    compared++; if (bus.rs1_busy !== 1'b1) begin mismatched++; $display("[TB] FAIL issue_busy got %b want 1", bus.rs1_busy); end
    compared++; if (bus.rs1_tag !== 4'd2) begin mismatched++; $display("[TB] FAIL issue_tag got %0d want 2", bus.rs1_tag); end
    bus.reg_done  = 1'b1;
    bus.reg_tag   = 4'd2;
    bus.reg_value = 32'hDEADBEEF;
    #1;
    compared++; if (bus.rs1_value !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL bypass_value got %h want deadbeef", bus.rs1_value); end
    compared++; if (bus.rs1_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL bypass_busy got %b want 0", bus.rs1_busy); end
    tick();
    idle();
    #1;
    compared++; if (bus.rs1_value !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL commit_value got %h want deadbeef", bus.rs1_value); end
    compared++; if (bus.rs1_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL commit_busy got %b want 0", bus.rs1_busy); end
  endtask

  task automatic test_stale_tag();
    issue(5'd4, 4'd1);
    issue(5'd4, 4'd5);
    bus.rs1_addr  = 5'd4;
    bus.reg_done  = 1'b1;
    bus.reg_tag   = 4'd1;
    bus.reg_value = 32'd7;
    #1;
    compared++; if (bus.rs1_busy !== 1'b1) begin mismatched++; $display("[TB] FAIL stale_no_bypass_busy got %b want 1", bus.rs1_busy); end
    compared++; if (bus.rs1_value !== 32'd0) begin mismatched++; $display("[TB] FAIL stale_no_bypass_value got %h want 0", bus.rs1_value); end
    tick();
    idle();
    #1;
    compared++; if (bus.rs1_value !== 32'd7) begin mismatched++; $display("[TB] FAIL stale_value got %h want 7", bus.rs1_value); end
    compared++; if (bus.rs1_busy !== 1'b1) begin mismatched++; $display("[TB] FAIL stale_busy got %b want 1", bus.rs1_busy); end
    compared++; if (bus.rs1_tag !== 4'd5) begin mismatched++; $display("[TB] FAIL stale_tag got %0d want 5", bus.rs1_tag); end
    bus.reg_done  = 1'b1;
    bus.reg_tag   = 4'd5;
    bus.reg_value = 32'd9;
    #1;
    compared++; if (bus.rs1_value !== 32'd9) begin mismatched++; $display("[TB] FAIL latest_bypass_value got %h want 9", bus.rs1_value); end
    tick();
    idle();
    #1;
    compared++; if (bus.rs1_value !== 32'd9) begin mismatched++; $display("[TB] FAIL latest_value got %h want 9", bus.rs1_value); end
    compared++; if (bus.rs1_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL latest_busy got %b want 0", bus.rs1_busy); end
  endtask

  task automatic test_same_cycle();
    issue(5'd8, 4'd6);
    bus.rs1_addr     = 5'd8;
    bus.reg_done     = 1'b1;
    bus.reg_tag      = 4'd6;
    bus.reg_value    = 32'hAA;
    bus.issue_signal = 1'b1;
    bus.issue_rd     = 5'd8;
    bus.issue_tag    = 4'd7;
    #1;
    compared++; if (bus.rs1_value !== 32'hAA) begin mismatched++; $display("[TB] FAIL same_cycle_read_value got %h want aa", bus.rs1_value); end
    compared++; if (bus.rs1_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL same_cycle_read_busy got %b want 0", bus.rs1_busy); end
    tick();
    idle();
    #1;
    compared++; if (bus.rs1_value !== 32'hAA) begin mismatched++; $display("[TB] FAIL same_cycle_value got %h want aa", bus.rs1_value); end
    compared++; if (bus.rs1_busy !== 1'b1) begin mismatched++; $display("[TB] FAIL same_cycle_busy got %b want 1", bus.rs1_busy); end
    compared++; if (bus.rs1_tag !== 4'd7) begin mismatched++; $display("[TB] FAIL same_cycle_tag got %0d want 7", bus.rs1_tag); end
  endtask

  task automatic test_clear();
    issue(5'd10, 4'd3);
    issue(5'd11, 4'd4);
    bus.clear_signal = 1'b1;
    bus.reg_done     = 1'b1;
    bus.reg_tag      = 4'd3;
    bus.reg_value    = 32'h55;
    bus.issue_signal = 1'b1;
    bus.issue_rd     = 5'd12;
    bus.issue_tag    = 4'd5;
    tick();
    idle();
    bus.rs1_addr = 5'd10;
    bus.rs2_addr = 5'd11;
    #1;
    compared++; if (bus.rs1_value !== 32'h55) begin mismatched++; $display("[TB] FAIL clear_commit_value got %h want 55", bus.rs1_value); end
    compared++; if (bus.rs1_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_busy_x10 got %b want 0", bus.rs1_busy); end
    compared++; if (bus.rs2_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_busy_x11 got %b want 0", bus.rs2_busy); end
    bus.rs1_addr = 5'd12;
    bus.rs2_addr = 5'd8;
    #1;
    compared++; if (bus.rs1_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_x12_busy got %b want 0", bus.rs1_busy); end
    compared++; if (bus.rs1_tag !== 4'd0) begin mismatched++; $display("[TB] FAIL clear_x12_tag got %0d want 0", bus.rs1_tag); end
    compared++; if (bus.rs2_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_busy_x8 got %b want 0", bus.rs2_busy); end
    // Tag 5 must still map to x4, not to the suppressed x12 rename.
    bus.reg_done  = 1'b1;
    bus.reg_tag   = 4'd5;
    bus.reg_value = 32'h77;
    tick();
    idle();
    bus.rs2_addr = 5'd4;
    #1;
    compared++; if (bus.rs1_value !== 32'd0) begin mismatched++; $display("[TB] FAIL clear_x12_value got %h want 0", bus.rs1_value); end
    compared++; if (bus.rs2_value !== 32'h77) begin mismatched++; $display("[TB] FAIL clear_tag5_x4_value got %h want 77", bus.rs2_value); end
  endtask

  task automatic test_x0();
    issue(5'd0, 4'd1);
    bus.rs1_addr  = 5'd0;
    bus.rs2_addr  = 5'd4;
    bus.reg_done  = 1'b1;
    bus.reg_tag   = 4'd1;
    bus.reg_value = 32'h1234;
    #1;
    compared++; if (bus.rs1_value !== 32'd0) begin mismatched++; $display("[TB] FAIL x0_bypass_value got %h want 0", bus.rs1_value); end
    compared++; if (bus.rs1_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL x0_busy got %b want 0", bus.rs1_busy); end
    tick();
    idle();
    #1;
    compared++; if (bus.rs1_value !== 32'd0) begin mismatched++; $display("[TB] FAIL x0_value got %h want 0", bus.rs1_value); end
    compared++; if (bus.rs2_value !== 32'h77) begin mismatched++; $display("[TB] FAIL x0_rename_x4_value got %h want 77", bus.rs2_value); end
  endtask

  task automatic test_stall();
    rdy_in           = 1'b0;
    bus.issue_signal = 1'b1;
    bus.issue_rd     = 5'd5;
    bus.issue_tag    = 4'd9;
    bus.reg_done     = 1'b1;
    bus.reg_tag      = 4'd3;
    bus.reg_value    = 32'h99;
    tick();
    tick();
    idle();
    rdy_in       = 1'b1;
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd10;
    #1;
    compared++; if (bus.rs1_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_x5_busy got %b want 0", bus.rs1_busy); end
    compared++; if (bus.rs2_value !== 32'h55) begin mismatched++; $display("[TB] FAIL stall_x10_value got %h want 55", bus.rs2_value); end
    // Tag 9 was never mapped, so this commit has no destination.
    bus.reg_done  = 1'b1;
    bus.reg_tag   = 4'd9;
    bus.reg_value = 32'h66;
    tick();
    idle();
    #1;
    compared++; if (bus.rs1_value !== 32'd0) begin mismatched++; $display("[TB] FAIL stall_x5_value got %h want 0", bus.rs1_value); end
  endtask

  task automatic test_reset_priority();
    rdy_in = 1'b0;
    rst_in = 1'b1;
    bus.rs1_addr = 5'd10;
    bus.rs2_addr = 5'd8;
    tick();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    #1;
    compared++; if (bus.rs1_value !== 32'd0) begin mismatched++; $display("[TB] FAIL rst_prio_value got %h want 0", bus.rs1_value); end
    compared++; if (bus.rs2_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_prio_busy got %b want 0", bus.rs2_busy); end
    compared++; if (bus.rs2_tag !== 4'd0) begin mismatched++; $display("[TB] FAIL rst_prio_tag got %0d want 0", bus.rs2_tag); end
  endtask

  initial begin
    test_reset();
    test_issue_commit();
    test_stale_tag();
    test_same_cycle();
    test_clear();
    test_x0();
    test_stall();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
